// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file with pending scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // Low bit of port `port` inside a bus that packs one `width`-bit field per port.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register; a set and a clear on the same entry leave it set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = DEF_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set,
  input  logic [AW-1:0]   i_set_idx,
  input  logic            i_clr,
  input  logic [AW-1:0]   i_clr_idx,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr) w_clr_mask[i_clr_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: x0 reads zero, optional write-to-read bypass, pending scoreboard,
// and a post-reset scrub that zeroes storage one entry per cycle before accepting traffic.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREG   = DEF_NREG,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic                   ready
);

  logic [XLEN-1:0] r_mem [NREG];
  rf_state_t       r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_ready;

  logic            w_wr_en;
  logic            w_iss_en;
  logic [NREG-1:0] w_pending;

  // Entry 0 is never scrubbed or written; reads of x0 are forced to zero instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT;
      r_ptr   <= AW'(1);
      r_ready <= 1'b0;
    end else if (r_state == INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == AW'(NREG - 1)) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end

  assign w_wr_en  = (r_state == RUN) && we && (wa != '0);
  assign w_iss_en = (r_state == RUN) && iss_valid && (iss_rd != '0);

  // NOTE: storage has no reset; the scrub sequencer clears it, keeping the array a plain RAM.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst),
    .i_set     (w_iss_en),
    .i_set_idx (iss_rd),
    .i_clr     (w_wr_en),
    .i_clr_idx (wa),
    .o_pending (w_pending)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rd_addr[slice_lsb(gi, AW) +: AW];

    // A forwarded write is the producer completing, so the bypassed value is never busy.
    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (r_ready && (w_addr != '0)) begin
        if ((BYPASS != 0) && we && (wa == w_addr)) begin
          w_data = wd;
        end else begin
          w_data = r_mem[w_addr];
          w_busy = w_pending[w_addr];
        end
      end
    end

    assign rd_data[slice_lsb(gi, XLEN) +: XLEN] = w_data;
    assign rd_busy[gi]                          = w_busy;
  end

  assign ready = r_ready;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the RV32I core's successor pipeline: configurable width, depth and read-port count; x0 hard-wired to zero; optional same-cycle write-to-read bypass; a per-register pending scoreboard for hazard detection. Storage is not flop-reset. After reset, an internal scrub sequencer zeroes every entry one per cycle and holds `ready` low until done. Sits between decode (read/issue) and writeback (write) stages.

## Interface
- `XLEN`, 32, data width in bits
- `NREG`, 32, number of registers; power of two, ≥ 4
- `NUM_RD`, 2, read ports, 1..4
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports
- `AW`, localparam = $clog2(NREG), address width
- Reset and clock (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `rd_addr`  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
- `rd_data`  out  NUM_RD*XLEN  packed read data
- `rd_busy`  out  NUM_RD  1 = addressed register has an outstanding producer
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `wd`  in  XLEN  write data
- `iss_valid`  in  1  an instruction writing `iss_rd` issues this cycle
- `iss_rd`  in  AW  destination register of the issuing instruction
- `ready`  out  1  1 = scrub finished, block accepts writes/issues

## Operation
- States: INIT, RUN. Reset asserted → INIT, scrub pointer = 1, all pending bits 0, `ready` = 0; storage array untouched by reset.
- INIT: each rising edge writes 0 to entry[ptr], ptr++. Edge that writes entry NREG-1 moves to RUN. `we`/`iss_valid` ignored. All `rd_data` = 0, `rd_busy` = 0.
- RUN: `ready` = 1, stays until next reset.
- Read (combinational, per port): addr 0 → data 0, busy 0. Else if BYPASS && `we` && `wa`==addr → data `wd`, busy 0. Else data entry[addr], busy pending[addr].
- Write: `we` && `wa`≠0 in RUN → entry[wa] ← wd at edge; pending[wa] cleared. `wa`=0 is a no-op. Writing a non-pending register is legal.
- Issue: `iss_valid` && `iss_rd`≠0 in RUN → pending[iss_rd] set at edge. Issue to an already-pending register leaves it set (single-bit, no count).
- Simultaneous write and issue to the same register: data written, pending ends **set** (the new producer wins).
- Reset mid-scrub or mid-RUN: immediate return to INIT, pointer to 1, pending cleared, scrub restarts from entry 1.

## Timing
- Read latency 0 (combinational from `rd_addr`, and from `we`/`wa`/`wd` when BYPASS=1).
- With BYPASS=0, written data is visible on reads the cycle after the write edge.
- Pending set/clear visible the cycle after the edge.
- `ready` rises exactly NREG-1 rising edges after `rst` deasserts; `ready` deasserts asynchronously with reset.
- Outputs during reset: `rd_data` 0, `rd_busy` 0, `ready` 0.

## Structure
- Package `regfile_pkg`: state enum `rf_state_t` {INIT, RUN}, default XLEN/NREG constants, a helper function that extracts the packed port slice.
- Sub-module `regfile_scoreboard`: NREG pending bits, set/clear ports with set-priority, async active-low reset; the top module instantiates it once.
- The storage array and scrub FSM stay in the top module. Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset release, NREG=32 → `ready` low for exactly 31 edges, then high; all reads return 0 throughout.
- RUN, write x5=0xDEADBEEF, BYPASS=1, port0 addr 5 in the same cycle → `rd_data` port0 = 0xDEADBEEF combinationally; BYPASS=0 → old value 0, new value the next cycle.
- Write x0=0x1234, then read x0 → 0. Issue x0 → `rd_busy` stays 0.
- Issue x7, next cycle port1 reads x7 → busy 1. Write x7=0x55 → busy 0 during the write cycle (bypass), and pending is clear afterward.
- Same-edge write x9=0xA and issue x9 → data 0xA, busy 1 the next cycle.
- Write x3=0xFF, assert reset mid-RUN and again mid-scrub at pointer 10 → pending cleared, scrub restarts from 1, x3 reads 0 after `ready` rises.
